// File: rtl/adder64_seq.sv
// Multi-cycle 64-bit adder: one SLICE_W-bit slice per clock, LSB first, registered carry.
// Optional ADDER64_SEQ_SUB_EN adds a 'sub' input that turns the operation into operand1 - operand2.
module adder64_seq #(
    parameter int unsigned SLICE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] operand1,
    input  logic [63:0] operand2,
    input  logic        cin,
`ifdef ADDER64_SEQ_SUB_EN
    input  logic        sub,
`endif
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        cout,
    output logic        overflow
);
    localparam int unsigned NSLICE = 64 / SLICE_W;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (SLICE_W != 8 && SLICE_W != 16 && SLICE_W != 32 && SLICE_W != 64) begin : g_bad_slice_w
        $error("adder64_seq: SLICE_W must be 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [63:0]         a_q, a_d;
    logic [63:0]         b_q, b_d;
    logic                carry_q, carry_d;
    logic [KW-1:0]       k_q, k_d;
    logic [63:0]         sum_q, sum_d;
    logic [63:0]         result_q, result_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, done_q;

    logic [5:0]          base;
    logic [SLICE_W:0]    slice_sum;
    logic [63:0]         b_eff;
    logic                c_eff;

    // Subtraction is folded into capture: B is stored already inverted with carry-in forced to 1.
    always_comb begin
        b_eff = operand2;
        c_eff = cin;
`ifdef ADDER64_SEQ_SUB_EN
        if (sub) begin
            b_eff = ~operand2;
            c_eff = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        k_d      = k_q;
        sum_d    = sum_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        base      = 6'(32'(k_q) * SLICE_W);
        slice_sum = {1'b0, a_q[base +: SLICE_W]} + {1'b0, b_q[base +: SLICE_W]}
                  + {{SLICE_W{1'b0}}, carry_q};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = operand1;
                    b_d     = b_eff;
                    carry_d = c_eff;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[base +: SLICE_W] = slice_sum[SLICE_W-1:0];
                carry_d = slice_sum[SLICE_W];
                k_d     = k_q + 1'b1;
                if (k_q == KW'(NSLICE - 1)) begin
                    result_d = sum_d;
                    cout_d   = slice_sum[SLICE_W];
                    ovf_d    = (a_q[63] == b_q[63]) && (sum_d[63] != a_q[63]);
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_adder64_seq.sv
// Self-checking bench for adder64_seq: directed cases plus random operations against an arithmetic model.
module tb_adder64_seq;
    parameter int unsigned SLICE_W = 16;
    localparam int unsigned NSLICE = 64 / SLICE_W;
`ifdef ADDER64_SEQ_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [63:0] operand1, operand2;
    logic        cin;
`ifdef ADDER64_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy, done, cout, overflow;
    logic [63:0] result;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] last_result = '0;

    adder64_seq #(.SLICE_W(SLICE_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .operand1 (operand1),
        .operand2 (operand2),
        .cin      (cin),
`ifdef ADDER64_SEQ_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #50 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: true integer arithmetic; overflow when the exact signed result does not fit in 64 bits.
    task automatic ref_op(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s,
                          output logic [63:0] r, output logic co, output logic ov);
        logic [65:0] sa, sb, st;
        logic [64:0] full;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        if (s) begin
            r  = a - b;
            co = (a >= b);
            st = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b} + 65'(c);
            r    = full[63:0];
            co   = full[64];
            st   = sa + sb + 66'(c);
        end
        ov = !((st[65:63] == 3'b000) || (st[65:63] == 3'b111));
    endtask

    task automatic drive_ops(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
        operand1 = a;
        operand2 = b;
        cin      = c;
`ifdef ADDER64_SEQ_SUB_EN
        sub      = s;
`endif
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s);
        logic [63:0] er;
        logic        eco, eov;
        int          cyc;
        bit          seen;
        ref_op(a, b, c, s, er, eco, eov);
        @(negedge clk);
        drive_ops(a, b, c, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_ops(~a, {$urandom, $urandom}, ~c, ~s);
        check_eq({tag, "/busy_on"}, 64'(busy), 64'd1);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= int'(NSLICE) + 8; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
            check_eq({tag, "/held"}, result, last_result);
        end
        check_eq({tag, "/done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check_eq({tag, "/latency"}, 64'(cyc), 64'(NSLICE));
            check_eq({tag, "/result"}, result, er);
            check_eq({tag, "/cout"}, 64'(cout), 64'(eco));
            check_eq({tag, "/overflow"}, 64'(overflow), 64'(eov));
            @(posedge clk); #1;
            check_eq({tag, "/done_pulse"}, 64'(done), 64'd0);
            check_eq({tag, "/busy_off"}, 64'(busy), 64'd0);
            check_eq({tag, "/result_hold"}, result, er);
        end
        last_result = er;
    endtask

    initial begin
        int          ndone;
        int          rst_edge;
        int          q_done[$];
        logic [63:0] ra, rb, er;
        logic        rc, rs, eco, eov;

        resetn = 1'b0;
        start  = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset/busy", 64'(busy), 64'd0);
        check_eq("reset/done", 64'(done), 64'd0);
        check_eq("reset/result", result, 64'd0);
        check_eq("reset/cout", 64'(cout), 64'd0);
        check_eq("reset/overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;

        run_op("carry32", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        run_op("ripple_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        if (HAS_SUB) begin
            run_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1);
            run_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1);
            run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        end

        // Second start during an operation must be ignored.
        ndone = 0;
        @(negedge clk);
        drive_ops(64'd3, 64'd4, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        if (done) ndone++;
        drive_ops(64'h10, 64'h10, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        if (done) ndone++;
        start = 1'b0;
        drive_ops(64'h55, 64'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 3 * (int'(NSLICE) + 2); i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check_eq("ignore/done_count", 64'(ndone), 64'd1);
        check_eq("ignore/result", result, 64'd7);
        check_eq("ignore/busy", 64'(busy), 64'd0);
        last_result = 64'd7;

        // Reset in the middle of RUN aborts without done.
        rst_edge = (NSLICE >= 3) ? 3 : int'(NSLICE);
        @(negedge clk);
        drive_ops(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (rst_edge - 1) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check_eq("abort/busy", 64'(busy), 64'd0);
        check_eq("abort/done", 64'(done), 64'd0);
        check_eq("abort/result", result, 64'd0);
        check_eq("abort/cout", 64'(cout), 64'd0);
        check_eq("abort/overflow", 64'(overflow), 64'd0);
        ndone = 0;
        for (int i = 0; i < int'(NSLICE) + 3; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check_eq("abort/no_done", 64'(ndone), 64'd0);
        last_result = '0;
        run_op("after_abort", 64'd1, 64'd1, 1'b0, 1'b0);

        // start held high: back-to-back operations every NSLICE+2 cycles.
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        ref_op(ra, rb, 1'b0, 1'b0, er, eco, eov);
        @(negedge clk);
        drive_ops(ra, rb, 1'b0, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 3 * (int'(NSLICE) + 2); i++) begin
            @(posedge clk); #1;
            if (done) begin
                q_done.push_back(i);
                check_eq("b2b/result", result, er);
            end
        end
        start = 1'b0;
        check_eq("b2b/two_dones", 64'(q_done.size() >= 2), 64'd1);
        if (q_done.size() >= 2)
            check_eq("b2b/period", 64'(q_done[1] - q_done[0]), 64'(NSLICE + 2));
        for (int i = 0; i < int'(NSLICE) + 4 && busy; i++) begin
            @(posedge clk); #1;
        end
        check_eq("b2b/idle", 64'(busy), 64'd0);
        last_result = er;

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: ra = {$urandom, $urandom};
                1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                2: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                default: ra = 64'h8000_0000_0000_0000 | 64'($urandom);
            endcase
            rb = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : ~ra;
            rc = 1'($urandom);
            rs = HAS_SUB ? 1'($urandom) : 1'b0;
            run_op("random", ra, rb, rc, rs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
